// File: rtl/uart_tx_serializer_if.sv
// rtl/uart_tx_serializer_if.sv - fifo head / pop handshake between the TX fifo and the serializer
interface uart_tx_serializer_if;
    logic [7:0] fifo_dout;
    logic       fifo_empty;
    logic       pop;

    modport master (
        output fifo_dout,
        output fifo_empty,
        input  pop
    );

    modport slave (
        input  fifo_dout,
        input  fifo_empty,
        output pop
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART TX frame serializer fed from the fifo head
// Parity generation and the PARITY state exist only when UART_TX_PARITY_EN is defined.
module uart_tx_serializer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 baud_pulse,
    uart_tx_serializer_if.slave  fifo,
    input  logic [1:0]           wlen,
    input  logic                 stb,
    input  logic                 pen,
    input  logic                 eps,
    output logic                 tx,
    output logic                 busy,
    output logic                 temt
);
    localparam int PW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(OVERSAMPLE - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, PARITY = 3'd4} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;
`endif

    state_t          r_state, w_state;
    logic [7:0]      r_shift, w_shift;
    logic [1:0]      r_wlen,  w_wlen;
    logic            r_stb,   w_stb;
    logic [PW-1:0]   r_pcnt,  w_pcnt;
    logic [2:0]      r_bcnt,  w_bcnt;
    logic            r_tx,    w_tx;
    logic            r_busy,  w_busy;
    logic            w_pop;
    logic            w_load;
    logic            w_bit_end;
    logic            w_last_data;
`ifdef UART_TX_PARITY_EN
    logic            r_pen, w_pen;
    logic            r_eps, w_eps;
    logic            r_par, w_par;
`else
    logic            w_unused_cfg;
    assign w_unused_cfg = pen ^ eps;
`endif

    assign w_load      = (r_state == IDLE) && en && !fifo.fifo_empty;
    assign w_bit_end   = baud_pulse && (r_pcnt == PCNT_LAST);
    assign w_last_data = (r_bcnt == ({1'b0, r_wlen} + 3'd4));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_wlen  <= '0;
            r_stb   <= 1'b0;
            r_pcnt  <= '0;
            r_bcnt  <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_pen   <= 1'b0;
            r_eps   <= 1'b0;
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state;
            r_shift <= w_shift;
            r_wlen  <= w_wlen;
            r_stb   <= w_stb;
            r_pcnt  <= w_pcnt;
            r_bcnt  <= w_bcnt;
            r_tx    <= w_tx;
            r_busy  <= w_busy;
`ifdef UART_TX_PARITY_EN
            r_pen   <= w_pen;
            r_eps   <= w_eps;
            r_par   <= w_par;
`endif
        end
    end

    always_comb begin
        w_state = r_state;
        w_shift = r_shift;
        w_wlen  = r_wlen;
        w_stb   = r_stb;
        w_pcnt  = r_pcnt;
        w_bcnt  = r_bcnt;
        w_tx    = r_tx;
        w_busy  = r_busy;
        w_pop   = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_pen   = r_pen;
        w_eps   = r_eps;
        w_par   = r_par;
`endif
        // Pulse counter runs in every bit state and wraps at each bit boundary.
        if (r_state != IDLE && baud_pulse) begin
            w_pcnt = w_bit_end ? '0 : r_pcnt + 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (w_load) begin
                    w_pop   = 1'b1;
                    w_shift = fifo.fifo_dout;
                    w_wlen  = wlen;
                    w_stb   = stb;
                    w_pcnt  = '0;
                    w_bcnt  = '0;
                    w_tx    = 1'b0;
                    w_busy  = 1'b1;
                    w_state = START;
`ifdef UART_TX_PARITY_EN
                    w_pen   = pen;
                    w_eps   = eps;
                    w_par   = 1'b0;
`endif
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_tx    = r_shift[0];
                    w_state = DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
`ifdef UART_TX_PARITY_EN
                    w_par = r_par ^ r_shift[0];
`endif
                    if (w_last_data) begin
                        w_bcnt = '0;
`ifdef UART_TX_PARITY_EN
                        if (r_pen) begin
                            w_tx    = r_eps ? w_par : ~w_par;
                            w_state = PARITY;
                        end else begin
                            w_tx    = 1'b1;
                            w_state = STOP;
                        end
`else
                        w_tx    = 1'b1;
                        w_state = STOP;
`endif
                    end else begin
                        w_bcnt  = r_bcnt + 1'b1;
                        w_shift = {1'b0, r_shift[7:1]};
                        w_tx    = r_shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_bit_end) begin
                    w_tx    = 1'b1;
                    w_state = STOP;
                end
            end
`endif
            STOP: begin
                // Bit counter doubles as the stop-bit counter for the two-stop-bit case.
                if (w_bit_end) begin
                    if (r_stb && (r_bcnt == 3'd0)) begin
                        w_bcnt = 3'd1;
                    end else begin
                        w_bcnt  = '0;
                        w_busy  = 1'b0;
                        w_state = IDLE;
                    end
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign fifo.pop = w_pop & rst;
    assign tx       = r_tx;
    assign busy     = r_busy;
    assign temt     = (r_state == IDLE) && fifo.fifo_empty;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - scoreboard bench for uart_tx_serializer with a frame-level reference model
module tb_uart_tx_serializer;
    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       baud_pulse = 1'b0;
    logic [1:0] wlen = 2'd3;
    logic       stb = 1'b0;
    logic       pen = 1'b0;
    logic       eps = 1'b0;
    logic       tx, busy, temt;

    uart_tx_serializer_if ifc();

    uart_tx_serializer #(.OVERSAMPLE(OS)) dut (
        .clk(clk), .rst(rst), .en(en), .baud_pulse(baud_pulse), .fifo(ifc.slave),
        .wlen(wlen), .stb(stb), .pen(pen), .eps(eps), .tx(tx), .busy(busy), .temt(temt)
    );

    typedef struct {
        logic [7:0] data;
        logic [1:0] wlen;
        logic       stb;
        logic       pen;
        logic       eps;
    } frame_t;
    typedef logic bitq_t[$];

    frame_t     sb[$];
    logic [7:0] fq[$];
    int n_checks = 0, n_fail = 0, n_pops = 0, n_frames = 0, n_aborted = 0;
    int baud_div = 2;
    logic mon_busy = 1'b0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void refresh();
        ifc.fifo_empty = (fq.size() == 0);
        ifc.fifo_dout  = (fq.size() != 0) ? fq[0] : 8'($urandom);
    endfunction

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        refresh();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line-level frame: start, data LSB first, optional parity, stop bit(s).
    function automatic bitq_t expected_bits(input frame_t f);
        bitq_t b;
        int nd;
        nd = int'(f.wlen) + 5;
        b.push_back(1'b0);
        for (int i = 0; i < nd; i++) b.push_back(f.data[i]);
`ifdef UART_TX_PARITY_EN
        if (f.pen) begin
            logic p;
            p = 1'b0;
            for (int i = 0; i < nd; i++) p = p ^ f.data[i];
            b.push_back(f.eps ? p : ~p);
        end
`endif
        for (int i = 0; i < (f.stb ? 2 : 1); i++) b.push_back(1'b1);
        return b;
    endfunction

    initial begin
        int c;
        c = 0;
        forever begin
            @(posedge clk);
            #1;
            if (baud_div <= 1) baud_pulse = 1'b1;
            else begin
                c++;
                if (c >= baud_div) begin c = 0; baud_pulse = 1'b1; end
                else baud_pulse = 1'b0;
            end
        end
    end

    // Fifo model: a pop seen before an edge consumes the head at that edge.
    initial begin
        logic p;
        frame_t f;
        forever begin
            @(negedge clk);
            p = ifc.pop;
            if (p) begin
                n_pops++;
                check("pop_while_empty", {31'd0, fq.size() != 0}, 32'd1);
                if (fq.size() != 0) begin
                    f.data = fq[0]; f.wlen = wlen; f.stb = stb; f.pen = pen; f.eps = eps;
                    sb.push_back(f);
                end
            end
            @(posedge clk);
            #1;
            if (p && fq.size() != 0) begin
                void'(fq.pop_front());
                refresh();
            end
        end
    end

    initial begin
        frame_t f;
        bitq_t eb;
        logic smp[$];
        int total, budget, good;
        logic ok_busy, aborted, start_now, exp_load;
        start_now = 1'b0;
        forever begin
            if (!start_now) begin
                @(negedge clk);
                if (!(rst && busy)) continue;
            end
            start_now = 1'b0;
            mon_busy = 1'b1;
            if (sb.size() == 0) begin
                check("frame_without_pop", 32'd0, 32'd1);
                for (int k = 0; k < 5000 && busy; k++) @(negedge clk);
                mon_busy = 1'b0;
                continue;
            end
            f = sb.pop_front();
            eb = expected_bits(f);
            total = eb.size() * OS;
            smp.delete();
            ok_busy = 1'b1;
            aborted = 1'b0;
            budget = 0;
            forever begin
                if (!rst) begin aborted = 1'b1; break; end
                if (baud_pulse) begin
                    smp.push_back(tx);
                    if (busy !== 1'b1) ok_busy = 1'b0;
                end
                if (smp.size() == total) break;
                if (budget > total * 4 + 50) break;
                @(negedge clk);
                budget++;
            end
            if (aborted) begin n_aborted++; mon_busy = 1'b0; continue; end
            check("frame_pulse_count", smp.size(), total);
            if (smp.size() != total) begin mon_busy = 1'b0; continue; end
            for (int k = 0; k < eb.size(); k++) begin
                good = 0;
                for (int s = 0; s < OS; s++) if (smp[k * OS + s] === eb[k]) good++;
                check($sformatf("frame%0d_data%02h_bit%0d_matching_samples", n_frames, f.data, k), good, OS);
            end
            check("busy_during_frame", {31'd0, ok_busy}, 32'd1);
            n_frames++;
            @(negedge clk);
            if (!rst) begin mon_busy = 1'b0; continue; end
            check("end_busy", {31'd0, busy}, 32'd0);
            check("end_tx", {31'd0, tx}, 32'd1);
            exp_load = en && (fq.size() != 0);
            check("idle_cycle_pop", {31'd0, ifc.pop}, {31'd0, exp_load});
            @(negedge clk);
            if (!rst) begin mon_busy = 1'b0; continue; end
            check("next_cycle_tx", {31'd0, tx}, {31'd0, ~exp_load});
            check("next_cycle_busy", {31'd0, busy}, {31'd0, exp_load});
            mon_busy = 1'b0;
            start_now = exp_load;
        end
    end

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (n < limit && (fq.size() != 0 || busy || mon_busy || sb.size() != 0)) begin
            @(negedge clk);
            n++;
        end
        check("drain_within_budget", {31'd0, n < limit}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, viol, n;
        refresh();
        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_pop", {31'd0, ifc.pop}, 32'd0);
        check("reset_temt", {31'd0, temt}, 32'd1);

        // 8N1 0x55, loaded while still in reset
        tick(); en = 1'b1; wlen = 2'd3; stb = 1'b0; p0 = n_pops; push(8'h55);
        @(negedge clk);
        check("reset_pop_blocked", {31'd0, ifc.pop}, 32'd0);
        check("temt_with_data", {31'd0, temt}, 32'd0);
        tick(); rst = 1'b1;
        wait_idle(2000);
        check("8n1_pop_count", n_pops - p0, 1);
        check("8n1_temt_after", {31'd0, temt}, 32'd1);

        // 5 data bits, 2 stop bits; upper byte bits must not appear
        tick(); wlen = 2'd0; stb = 1'b1; push(8'hFF);
        wait_idle(2000);
        tick(); stb = 1'b0; push(8'hE0);
        wait_idle(2000);

`ifdef UART_TX_PARITY_EN
        tick(); wlen = 2'd3; pen = 1'b1; eps = 1'b1; push(8'h07);
        wait_idle(3000);
        tick(); eps = 1'b0; push(8'h07);
        wait_idle(3000);
        tick(); pen = 1'b0;
`endif

        // three queued bytes, back to back
        tick(); wlen = 2'd3; stb = 1'b0; baud_div = 1; p0 = n_pops;
        push(8'hA1); push(8'h3C); push(8'hF0);
        wait_idle(3000);
        check("b2b_pop_count", n_pops - p0, 3);

        // transmitter disabled with data waiting
        tick(); en = 1'b0; push(8'h5A); viol = 0;
        repeat (1000) begin
            @(negedge clk);
            if (ifc.pop !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) viol++;
        end
        check("disabled_violations", viol, 0);
        tick(); en = 1'b1;
        @(negedge clk);
        check("pop_after_enable", {31'd0, ifc.pop}, 32'd1);
        wait_idle(2000);

        // reset in the middle of the data bits
        tick(); push(8'hC3); push(8'h6B);
        n = 0;
        while (!busy && n < 100) begin @(negedge clk); n++; end
        check("busy_before_reset", {31'd0, busy}, 32'd1);
        repeat (40) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("async_reset_tx", {31'd0, tx}, 32'd1);
        check("async_reset_busy", {31'd0, busy}, 32'd0);
        tick(); rst = 1'b1;
        wait_idle(2000);
        check("reset_aborted_frames", n_aborted, 1);

        // randomized traffic with mid-frame config churn
        for (int i = 0; i < 30; i++) begin
            tick();
            wlen = 2'($urandom_range(0, 3));
            stb  = 1'($urandom_range(0, 1));
            pen  = 1'($urandom_range(0, 1));
            eps  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) baud_div = $urandom_range(1, 3);
            en = ($urandom_range(0, 7) != 0);
            push(8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 200)) @(posedge clk);
        end
        tick(); en = 1'b1;
        wait_idle(40000);

        check("frames_accounted", n_frames + n_aborted, n_pops);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
